// File: rtl/lif_neuron_core_if.sv
// Bus between one LIF neuron, its stimulus/weight-store side and the STDP stage.
// Signal names match the legacy port list so existing hookups carry over unchanged.
interface lif_neuron_core_if #(
  parameter int N_SYN   = 16,
  parameter int W_WIDTH = 4,
  parameter int V_WIDTH = 10
);
  localparam int AW = $clog2(N_SYN);

  logic               step;
  logic [N_SYN-1:0]   pre_spike;
  logic [AW-1:0]      weight_addr;
  logic [W_WIDTH-1:0] weight_data;
  logic               post_spike;
  logic [V_WIDTH-1:0] membrane;
  logic               busy;
  logic               done;

  modport master (
    output step, pre_spike, weight_data,
    input  weight_addr, post_spike, membrane, busy, done
  );

  modport slave (
    input  step, pre_spike, weight_data,
    output weight_addr, post_spike, membrane, busy, done
  );
endinterface

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: scans all synapses per timestep, integrates the
// weighted spike sum into a leaky saturating membrane, fires and enters refractory.
module lif_neuron_core #(
  parameter int N_SYN      = 16,
  parameter int W_WIDTH    = 4,
  parameter int V_WIDTH    = 10,
  parameter int THRESHOLD  = 64,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 2
) (
  input  logic              clock,
  input  logic              reset,
  lif_neuron_core_if.slave  bus
);
  localparam int AW    = $clog2(N_SYN);
  localparam int CW    = $clog2(N_SYN + 1);
  localparam int ACC_W = $clog2(N_SYN * ((1 << W_WIDTH) - 1) + 1);
  localparam int RW    = $clog2(REFRACT + 2);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SCAN    = 2'd1;
  localparam logic [1:0] ST_LEAK    = 2'd2;
  localparam logic [1:0] ST_REFRACT = 2'd3;

  localparam logic [V_WIDTH:0] VMAX = {1'b0, {V_WIDTH{1'b1}}};
  localparam logic [V_WIDTH:0] THR  = (V_WIDTH + 1)'(THRESHOLD);

  logic [1:0]         state;
  logic [N_SYN-1:0]   preQ;
  logic [CW-1:0]      scanCnt;
  logic               validD;
  logic [AW-1:0]      idxD;
  logic [ACC_W-1:0]   acc;
  logic [RW-1:0]      refractCnt;
  logic [V_WIDTH-1:0] membraneQ;
  logic               postSpikeQ;
  logic               doneQ;

  logic               issuing;
  logic               scanLast;
  logic [V_WIDTH:0]   vSum;
  logic [V_WIDTH:0]   vNext;

  assign issuing  = (state == ST_SCAN) && (scanCnt < CW'(N_SYN));
  assign scanLast = (scanCnt == CW'(N_SYN));

  // Extra headroom bit keeps the worst case (full membrane plus full sum) from wrapping.
  always_comb begin
    vSum  = {1'b0, membraneQ} - ({1'b0, membraneQ} >> LEAK_SHIFT)
          + {{(V_WIDTH + 1 - ACC_W){1'b0}}, acc};
    vNext = vSum;
    if (vSum > VMAX) vNext = VMAX;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      preQ       <= '0;
      scanCnt    <= '0;
      validD     <= 1'b0;
      idxD       <= '0;
      acc        <= '0;
      refractCnt <= '0;
      membraneQ  <= '0;
      postSpikeQ <= 1'b0;
      doneQ      <= 1'b0;
    end else begin
      doneQ      <= 1'b0;
      postSpikeQ <= 1'b0;
      case (state)
        ST_IDLE: begin
          validD <= 1'b0;
          if (bus.step) begin
            if (refractCnt != '0) begin
              state <= ST_REFRACT;
            end else begin
              preQ    <= bus.pre_spike;
              acc     <= '0;
              scanCnt <= '0;
              state   <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          // Weight store answers one cycle late, so the address index rides a one-stage pipe.
          validD <= issuing;
          idxD   <= scanCnt[AW-1:0];
          if (validD && preQ[idxD])
            acc <= acc + {{(ACC_W - W_WIDTH){1'b0}}, bus.weight_data};
          if (scanLast) state   <= ST_LEAK;
          else          scanCnt <= scanCnt + 1'b1;
        end
        ST_LEAK: begin
          doneQ <= 1'b1;
          if (vNext >= THR) begin
            membraneQ  <= '0;
            postSpikeQ <= 1'b1;
            refractCnt <= RW'(REFRACT);
          end else begin
            membraneQ <= vNext[V_WIDTH-1:0];
          end
          state <= ST_IDLE;
        end
        ST_REFRACT: begin
          refractCnt <= refractCnt - 1'b1;
          doneQ      <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.weight_addr = issuing ? scanCnt[AW-1:0] : '0;
  assign bus.post_spike  = postSpikeQ;
  assign bus.membrane    = membraneQ;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.done        = doneQ;
endmodule

// File: doc/lif_neuron_core.md
# lif_neuron_core

Leaky integrate-and-fire neuron serving one output neuron of the SNN array. It sits between the synaptic weight store and the STDP learning stage: per timestep it scans all presynaptic spike lines, reads each synapse's 4-bit weight, integrates the weighted sum into a leaky membrane potential, and emits the postsynaptic spike that drives the STDP block's post-synaptic input. Refractory handling and membrane saturation are built in.

## Interface
- N_SYN, 16, number of presynaptic inputs; weight_addr width is log2(N_SYN).
- W_WIDTH, 4, unsigned weight width.
- V_WIDTH, 10, unsigned membrane width.
- THRESHOLD, 64, firing threshold; must be ≤ 2^V_WIDTH−1.
- LEAK_SHIFT, 3, leak = v >> LEAK_SHIFT per timestep.
- REFRACT, 2, refractory timesteps after a spike.

- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low.
- step  in  1  timestep strobe; accepted only in IDLE.
- pre_spike  in  N_SYN  presynaptic spikes; latched on the accepting edge.
- weight_addr  out  log2(N_SYN)  synapse index to weight store.
- weight_data  in  W_WIDTH  weight for weight_addr, valid exactly one cycle after the address.
- post_spike  out  1  one-cycle fire pulse.
- membrane  out  V_WIDTH  registered membrane potential.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle end-of-timestep pulse.

## Operation
- States: IDLE, SCAN, LEAK, REFRACT.
- IDLE: weight_addr = 0. On step=1: if refract_cnt > 0, go to REFRACT. Otherwise latch pre_q ← pre_spike, clear acc and addr_cnt, and go to SCAN.
- SCAN: runs for 17 cycles.
  - weight_addr = addr_cnt for addresses 0..15.
  - A one-cycle-delayed index/valid pipeline consumes weight_data. If valid_d && pre_q[idx_d], then acc += weight_data.
  - acc is 8 bits; the maximum value is 16×15 = 240, so it cannot overflow.
  - After the 17th cycle, go to LEAK.
- LEAK: compute v_next = v − (v >> LEAK_SHIFT) + acc in V_WIDTH+1 bits, saturating at 2^V_WIDTH−1.
  - If v_next ≥ THRESHOLD: membrane ← 0, post_spike ← 1, refract_cnt ← REFRACT.
  - Else: membrane ← v_next.
  - In both cases done ← 1, then go to IDLE.
- REFRACT: pre_spike is ignored, no addresses are issued, membrane is held, refract_cnt decrements, done ← 1, then go to IDLE.
- step while busy: ignored, with no queuing.
- step in the same cycle done is high: accepted, because the state is IDLE.

## Timing
- Reset values: state IDLE; membrane, acc, refract_cnt, weight_addr, post_spike, done, busy all 0.
- Reset asserted mid-timestep aborts the timestep immediately. No done or post_spike is produced for it.
- Normal timestep, with edge E0 accepting step:
  - busy is high from after E0.
  - weight_addr = k during cycle k+1, for k = 0..15.
  - done, post_spike and the new membrane value are registered at E18 and visible for one cycle.
  - busy falls at E18.
  - Step-to-done latency is 18 cycles.
- Refractory timestep: done is visible after E1, so latency is 1 cycle. membrane stays 0.
- post_spike is only ever high in a cycle where done is also high.

## Test plan
- Reset: hold reset=0 with random inputs → all outputs 0. Release reset → outputs stay 0 until a step is accepted.
- Single synapse: weight[0]=5, pre_spike=16'h0001, step →
  - weight_addr walks 0..15, one per cycle, starting the cycle after E0.
  - done at E18 with membrane=5 and post_spike=0.
- Leak: preload membrane=40 through prior steps, then step with pre_spike=0 → membrane=35 at done.
- Fire and refractory: all weights=4, pre_spike=16'hFFFF, membrane=0, step →
  - acc=64 ≥ 64, so post_spike and done both pulse and membrane=0.
  - The next two steps are refractory: done 1 cycle after accept, weight_addr stays 0, membrane stays 0.
  - The third step integrates normally (64 again, so it fires again).
- Saturation: build with THRESHOLD=1023 and all weights=15, pre_spike=16'hFFFF, repeated steps → membrane climbs 240, 450, …, clamps at 1023 without wrapping, then fires.
- Busy and reset: pulse step at E0 and again at E5 → only one done. Assert reset during SCAN cycle 8 → immediate return to IDLE, no done, membrane 0.
